player_square: RTL and testbench
================================

PLAYER_SQUARE -- requirements
Module: player_square

Interface
REQ-001 SHALL have parameter OBJECT_WIDTH_X, default 32, sprite width in pixels.
REQ-002 SHALL have parameter OBJECT_HEIGHT_Y, default 20, sprite height in pixels.
REQ-003 SHALL have parameter INITIAL_X, default 304, top-left X after reset.
REQ-004 SHALL have parameter Y_POS, default 400, fixed top-left Y.
REQ-005 SHALL have parameter SPEED, default 4, pixels moved per frame.
REQ-006 SHALL have parameter RIGHT_LIMIT, default 639, last legal screen column; left limit is column 0.
REQ-007 SHALL have parameter FREEZE_FRAMES, default 60, frames held frozen after collision.
REQ-008 SHALL have port clk  input  1  system clock (all state on rising edge).
REQ-009 SHALL have port resetN  input  1  reset, asynchronous and active-low.
REQ-010 SHALL have port pixelX  input  11  current scan column.
REQ-011 SHALL have port pixelY  input  11  current scan row.
REQ-012 SHALL have port startOfFrame  input  1  one-cycle pulse per frame.
REQ-013 SHALL have port leftKey  input  1  level, move-left request.
REQ-014 SHALL have port rightKey  input  1  level, move-right request.
REQ-015 SHALL have port collision  input  1  one-cycle hit pulse from collision logic.
REQ-016 SHALL have port offsetX  output  11  pixelX minus top-left X, to bitmap stage.
REQ-017 SHALL have port offsetY  output  11  pixelY minus top-left Y, to bitmap stage.
REQ-018 SHALL have port InsideRectangle  output  1  pixel lies within sprite box.
REQ-019 SHALL have port topLeftX  output  11  current registered sprite X.
REQ-020 SHALL have port frozen  output  1  high while in FROZEN state.

Function
REQ-021 SHALL implement FSM states IDLE, WALK_L, WALK_R, FROZEN; state and position change only on cycles with startOfFrame=1, except collision capture (REQ-026).
REQ-022 On startOfFrame, outside FROZEN: leftKey only -> WALK_L; rightKey only -> WALK_R; neither or both -> IDLE.
REQ-023 WALK_L SHALL subtract SPEED from topLeftX per frame, clamped at 0 (no wrap below 0).
REQ-024 WALK_R SHALL add SPEED per frame, clamped so topLeftX+OBJECT_WIDTH_X-1 never exceeds RIGHT_LIMIT; computation in 12 bits, no overflow wrap.
REQ-025 Movement SHALL use the state entered on that same startOfFrame (key sampled and applied in one frame).
REQ-026 A collision pulse in any non-FROZEN state SHALL be latched on that cycle; at the next startOfFrame the FSM enters FROZEN, freeze counter loaded FREEZE_FRAMES, position unchanged.
REQ-027 collision and startOfFrame in the same cycle SHALL enter FROZEN immediately on that frame, with no movement.
REQ-028 In FROZEN, collision pulses SHALL be ignored (counter not reloaded); counter decrements each startOfFrame; on the frame it reads 1 the FSM returns to IDLE.
REQ-029 frozen SHALL be asserted exactly while state is FROZEN.
REQ-030 InsideRectangle SHALL be registered: 1 iff pixelX in [topLeftX, topLeftX+OBJECT_WIDTH_X-1] and pixelY in [Y_POS, Y_POS+OBJECT_HEIGHT_Y-1], one-cycle latency, compared in 12 bits.
REQ-031 offsetX/offsetY SHALL be registered alongside InsideRectangle with the same latency; value pixel minus top-left when inside, 0 when outside.
REQ-032 Rectangle compare SHALL use topLeftX as registered before the current cycle's update.

Reset
REQ-033 On resetN=0, asynchronously: state IDLE, topLeftX=INITIAL_X, freeze counter 0, collision latch 0, offsetX=0, offsetY=0, InsideRectangle=0, frozen=0.
REQ-034 Reset mid-FROZEN or mid-walk SHALL abandon the operation fully; first startOfFrame after release behaves as from IDLE.

Verification
REQ-035 Reset, rightKey=1, 3 frames -> topLeftX 304->308->312->316, state WALK_R.
REQ-036 topLeftX=6, leftKey=1, 2 frames -> 2 then 0, stays 0; topLeftX=604, rightKey -> 608, then clamped 608 (608+31=639).
REQ-037 Both keys held 5 frames -> topLeftX unchanged, state IDLE.
REQ-038 collision pulse then startOfFrame -> frozen=1, keys ignored; second collision mid-freeze ignored; frozen=0 after exactly 60 frames.
REQ-039 topLeftX=100: pixel (100,400) -> next cycle InsideRectangle=1, offset (0,0); (131,419) -> 1, (31,19); (132,400) and (100,420) -> 0, offsets 0.
REQ-040 resetN pulsed low while FROZEN with topLeftX=200 -> immediately topLeftX=304, frozen=0, InsideRectangle=0.

Source files
------------

// File: rtl/player_square_if.sv
// Bundles the per-pixel scan inputs, the key/collision controls and the
// sprite outputs of the player square into a single port.
interface player_square_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        leftKey;
    logic        rightKey;
    logic        collision;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic [10:0] topLeftX;
    logic        frozen;

    // Driver side: video timing, keyboard and collision logic
    modport master (
        output pixelX, pixelY, startOfFrame, leftKey, rightKey, collision,
        input  offsetX, offsetY, InsideRectangle, topLeftX, frozen
    );

    // Sprite side: the player square itself
    modport slave (
        input  pixelX, pixelY, startOfFrame, leftKey, rightKey, collision,
        output offsetX, offsetY, InsideRectangle, topLeftX, frozen
    );
endinterface

// File: rtl/player_square.sv
// Player sprite: moves left/right once per frame under key control, clamps
// at the screen edges, freezes for a number of frames after a collision and
// reports whether the current scan pixel falls inside the sprite box.
module player_square #(
    parameter int OBJECT_WIDTH_X  = 32,
    parameter int OBJECT_HEIGHT_Y = 20,
    parameter int INITIAL_X       = 304,
    parameter int Y_POS           = 400,
    parameter int SPEED           = 4,
    parameter int RIGHT_LIMIT     = 639,
    parameter int FREEZE_FRAMES   = 60
) (
    input  logic           clk,
    input  logic           resetN,
    player_square_if.slave bus
);

    // Wide enough to hold FREEZE_FRAMES, never zero bits
    localparam int CNT_W = $clog2(FREEZE_FRAMES + 2);

    // All position arithmetic is done in 12 bits so nothing wraps
    localparam logic [11:0] SPEED_12 = 12'(SPEED);
    localparam logic [11:0] MAX_X_12 = 12'(RIGHT_LIMIT - OBJECT_WIDTH_X + 1);
    localparam logic [11:0] WIDTH_M1 = 12'(OBJECT_WIDTH_X - 1);
    localparam logic [11:0] Y_LO_12  = 12'(Y_POS);
    localparam logic [11:0] Y_HI_12  = 12'(Y_POS + OBJECT_HEIGHT_Y - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_L = 2'd1,
        WALK_R = 2'd2,
        FROZEN = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [10:0]      pos_x_reg, pos_x_next;
    logic [CNT_W-1:0] freeze_cnt_reg, freeze_cnt_next;
    logic             hit_latch_reg, hit_latch_next;

    logic             inside_reg;
    logic [10:0]      offset_x_reg;
    logic [10:0]      offset_y_reg;

    logic [11:0] pos_12;
    logic [11:0] left_12;
    logic [11:0] right_12;
    logic [10:0] left_pos;
    logic [10:0] right_pos;

    logic [11:0] px_12;
    logic [11:0] py_12;
    logic [11:0] x_end_12;
    logic        in_rect;

    // Candidate positions for one step left/right, already clamped
    always_comb begin
        pos_12   = {1'b0, pos_x_reg};
        right_12 = pos_12 + SPEED_12;
        left_12  = (pos_12 < SPEED_12) ? 12'd0 : (pos_12 - SPEED_12);
        if (right_12 > MAX_X_12) begin
            right_12 = MAX_X_12;
        end
        left_pos  = left_12[10:0];
        right_pos = right_12[10:0];
    end

    // Next-state logic: everything except collision capture waits for startOfFrame
    always_comb begin
        state_next      = state_reg;
        pos_x_next      = pos_x_reg;
        freeze_cnt_next = freeze_cnt_reg;
        hit_latch_next  = hit_latch_reg;

        if (state_reg == FROZEN) begin
            // Collisions are ignored here; just count the freeze down
            if (bus.startOfFrame) begin
                if (freeze_cnt_reg <= CNT_W'(1)) begin
                    state_next      = IDLE;
                    freeze_cnt_next = '0;
                end else begin
                    freeze_cnt_next = freeze_cnt_reg - CNT_W'(1);
                end
            end
        end else if (bus.startOfFrame) begin
            if (hit_latch_reg || bus.collision) begin
                // A pending or simultaneous hit wins over any movement
                state_next      = FROZEN;
                freeze_cnt_next = CNT_W'(FREEZE_FRAMES);
                hit_latch_next  = 1'b0;
            end else if (bus.leftKey && !bus.rightKey) begin
                state_next = WALK_L;
                pos_x_next = left_pos;
            end else if (bus.rightKey && !bus.leftKey) begin
                state_next = WALK_R;
                pos_x_next = right_pos;
            end else begin
                state_next = IDLE;
            end
        end else if (bus.collision) begin
            hit_latch_next = 1'b1;
        end
    end

    // FSM, position, freeze counter and hit latch registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= IDLE;
            pos_x_reg      <= 11'(INITIAL_X);
            freeze_cnt_reg <= '0;
            hit_latch_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pos_x_reg      <= pos_x_next;
            freeze_cnt_reg <= freeze_cnt_next;
            hit_latch_reg  <= hit_latch_next;
        end
    end

    // Box test against the position held before this cycle's update
    always_comb begin
        px_12    = {1'b0, bus.pixelX};
        py_12    = {1'b0, bus.pixelY};
        x_end_12 = pos_12 + WIDTH_M1;
        in_rect  = (px_12 >= pos_12) && (px_12 <= x_end_12) &&
                   (py_12 >= Y_LO_12) && (py_12 <= Y_HI_12);
    end

    // Registered inside flag and bitmap offsets (zero when outside)
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            inside_reg   <= 1'b0;
            offset_x_reg <= '0;
            offset_y_reg <= '0;
        end else begin
            inside_reg <= in_rect;
            if (in_rect) begin
                offset_x_reg <= bus.pixelX - pos_x_reg;
                offset_y_reg <= bus.pixelY - 11'(Y_POS);
            end else begin
                offset_x_reg <= '0;
                offset_y_reg <= '0;
            end
        end
    end

    assign bus.topLeftX        = pos_x_reg;
    assign bus.frozen          = (state_reg == FROZEN);
    assign bus.InsideRectangle = inside_reg;
    assign bus.offsetX         = offset_x_reg;
    assign bus.offsetY         = offset_y_reg;

endmodule

// File: tb/tb_player_square.sv
// Self-checking bench for player_square: directed scenarios with literal
// expectations plus randomized frames checked every cycle against a
// frame-level behavioural model.
module tb_player_square;

    localparam int W    = 32;
    localparam int H    = 20;
    localparam int X0   = 304;
    localparam int YP   = 400;
    localparam int SPD  = 4;
    localparam int RLIM = 639;
    localparam int FF   = 60;

    logic clk;
    logic resetN;
    player_square_if bus ();

    player_square dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    bit chk_en;

    // Model: sprite x, frames of freeze still to serve, pending hit, box outputs
    int m_x;
    int m_frz;
    bit m_hit;
    int m_ins;
    int m_ox;
    int m_oy;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x   = X0;
        m_frz = 0;
        m_hit = 1'b0;
        m_ins = 0;
        m_ox  = 0;
        m_oy  = 0;
    endtask

    // One clock of the model, evaluated at the rising edge
    task automatic model_step();
        int px;
        int py;
        int nx;
        px = int'(bus.pixelX);
        py = int'(bus.pixelY);
        if (px >= m_x && px < m_x + W && py >= YP && py < YP + H) begin
            m_ins = 1;
            m_ox  = px - m_x;
            m_oy  = py - YP;
        end else begin
            m_ins = 0;
            m_ox  = 0;
            m_oy  = 0;
        end
        if (bus.startOfFrame) begin
            if (m_frz > 0) begin
                m_frz--;
            end else if (m_hit || bus.collision) begin
                m_frz = FF;
                m_hit = 1'b0;
            end else begin
                nx = m_x;
                if (bus.leftKey && !bus.rightKey) nx = m_x - SPD;
                if (bus.rightKey && !bus.leftKey) nx = m_x + SPD;
                if (nx < 0) nx = 0;
                if (nx + W - 1 > RLIM) nx = RLIM - W + 1;
                m_x = nx;
            end
        end else if (bus.collision && m_frz == 0) begin
            m_hit = 1'b1;
        end
    endtask

    // Compare process: every falling edge once the bench is armed
    always @(negedge clk) begin
        if (chk_en) begin
            chk("topLeftX", int'(bus.topLeftX), m_x);
            chk("frozen", int'(bus.frozen), (m_frz > 0) ? 1 : 0);
            chk("InsideRectangle", int'(bus.InsideRectangle), m_ins);
            chk("offsetX", int'(bus.offsetX), m_ox);
            chk("offsetY", int'(bus.offsetY), m_oy);
        end
    end

    // Advance one clock; inputs are set just after the previous edge
    task automatic tick();
        @(posedge clk);
        if (resetN) model_step();
        #1;
    endtask

    // One frame of four clocks; startOfFrame on the first, collision optional there
    task automatic frame(input bit l, input bit r, input bit c, input int px, input int py);
        for (int i = 0; i < 4; i++) begin
            bus.leftKey      = l;
            bus.rightKey     = r;
            bus.startOfFrame = (i == 0);
            bus.collision    = (i == 0) ? c : 1'b0;
            bus.pixelX       = 11'(px);
            bus.pixelY       = 11'(py);
            tick();
        end
        bus.startOfFrame = 1'b0;
        bus.collision    = 1'b0;
    endtask

    task automatic pulse_collision();
        bus.startOfFrame = 1'b0;
        bus.collision    = 1'b1;
        tick();
        bus.collision    = 1'b0;
    endtask

    task automatic set_pixel(input int px, input int py);
        bus.startOfFrame = 1'b0;
        bus.pixelX       = 11'(px);
        bus.pixelY       = 11'(py);
        tick();
    endtask

    task automatic pulse_reset();
        resetN = 1'b0;
        model_reset();
        #1;
        chk("reset_x_now", int'(bus.topLeftX), 304);
        chk("reset_frozen_now", int'(bus.frozen), 0);
        chk("reset_inside_now", int'(bus.InsideRectangle), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic random_frames(input int n);
        int px;
        int py;
        bit l;
        bit r;
        for (int f = 0; f < n; f++) begin
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                px = m_x + int'($urandom_range(0, 44)) - 6;
                if (px < 0) px = 0;
                py = YP + int'($urandom_range(0, 28)) - 4;
                bus.leftKey      = l;
                bus.rightKey     = r;
                bus.startOfFrame = (i == 0);
                bus.collision    = ($urandom_range(0, 47) == 0);
                bus.pixelX       = 11'(px);
                bus.pixelY       = 11'(py);
                tick();
            end
        end
        bus.collision    = 1'b0;
        bus.startOfFrame = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        resetN = 1'b0;
        bus.pixelX       = '0;
        bus.pixelY       = '0;
        bus.startOfFrame = 1'b0;
        bus.leftKey      = 1'b0;
        bus.rightKey     = 1'b0;
        bus.collision    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_topLeftX", int'(bus.topLeftX), 304);
        chk("rst_frozen", int'(bus.frozen), 0);
        chk("rst_inside", int'(bus.InsideRectangle), 0);
        resetN = 1'b1;
        chk_en = 1'b1;

        // Walk right three frames
        frame(0, 1, 0, 0, 0);
        chk("walk_r_1", int'(bus.topLeftX), 308);
        frame(0, 1, 0, 0, 0);
        chk("walk_r_2", int'(bus.topLeftX), 312);
        frame(0, 1, 0, 0, 0);
        chk("walk_r_3", int'(bus.topLeftX), 316);

        // Both keys: no movement
        repeat (5) frame(1, 1, 0, 0, 0);
        chk("both_keys", int'(bus.topLeftX), 316);

        // Left edge clamp
        repeat (78) frame(1, 0, 0, 0, 0);
        chk("left_at_4", int'(bus.topLeftX), 4);
        frame(1, 0, 0, 0, 0);
        chk("left_at_0", int'(bus.topLeftX), 0);
        frame(1, 0, 0, 0, 0);
        chk("left_stay_0", int'(bus.topLeftX), 0);

        // Right edge clamp: 604 -> 608 -> 608
        repeat (151) frame(0, 1, 0, 0, 0);
        chk("right_at_604", int'(bus.topLeftX), 604);
        frame(0, 1, 0, 0, 0);
        chk("right_at_608", int'(bus.topLeftX), 608);
        frame(0, 1, 0, 0, 0);
        chk("right_clamp", int'(bus.topLeftX), 608);

        // Back to 100 for the box checks
        repeat (127) frame(1, 0, 0, 0, 0);
        chk("x_at_100", int'(bus.topLeftX), 100);
        set_pixel(100, 400);
        chk("box_tl_in", int'(bus.InsideRectangle), 1);
        chk("box_tl_ox", int'(bus.offsetX), 0);
        chk("box_tl_oy", int'(bus.offsetY), 0);
        set_pixel(131, 419);
        chk("box_br_in", int'(bus.InsideRectangle), 1);
        chk("box_br_ox", int'(bus.offsetX), 31);
        chk("box_br_oy", int'(bus.offsetY), 19);
        set_pixel(132, 400);
        chk("box_xout_in", int'(bus.InsideRectangle), 0);
        chk("box_xout_ox", int'(bus.offsetX), 0);
        set_pixel(100, 420);
        chk("box_yout_in", int'(bus.InsideRectangle), 0);
        chk("box_yout_oy", int'(bus.offsetY), 0);

        // Latched collision, keys ignored, second hit ignored, 60-frame freeze
        pulse_collision();
        chk("latched_not_frozen_yet", int'(bus.frozen), 0);
        frame(1, 0, 0, 0, 0);
        chk("freeze_enter", int'(bus.frozen), 1);
        chk("freeze_no_move", int'(bus.topLeftX), 100);
        for (int f = 1; f < FF; f++) begin
            if (f == 30) pulse_collision();
            frame(0, 1, 0, 0, 0);
        end
        chk("freeze_frame_59", int'(bus.frozen), 1);
        chk("freeze_x_held", int'(bus.topLeftX), 100);
        frame(0, 1, 0, 0, 0);
        chk("freeze_released", int'(bus.frozen), 0);
        chk("release_no_move", int'(bus.topLeftX), 100);

        // Collision with startOfFrame, then reset mid-freeze
        repeat (25) frame(0, 1, 0, 0, 0);
        chk("x_at_200", int'(bus.topLeftX), 200);
        frame(1, 0, 1, 210, 405);
        chk("same_cycle_freeze", int'(bus.frozen), 1);
        chk("same_cycle_no_move", int'(bus.topLeftX), 200);
        frame(0, 0, 0, 210, 405);
        chk("inside_before_reset", int'(bus.InsideRectangle), 1);
        pulse_reset();
        frame(0, 1, 0, 0, 0);
        chk("after_reset_walk", int'(bus.topLeftX), 308);

        // Randomized traffic against the model
        random_frames(500);
        pulse_reset();
        random_frames(200);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
